jt51_kon_sched: RTL and testbench

- Key-on/key-off scheduler for the envelope generator.
- Holds the CPU-written key state for all 32 operator slots.
- Walks the slot sequence in lock-step with the operator pipeline and emits single-slot keyon/keyoff pulses on state edges.
- Sits between the register file (key-on register writes) and the envelope generator's keyon/keyoff inputs.

---
 rtl/jt51_kon_sched.sv | 100 ++++++++++
 tb/tb_jt51_kon_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_kon_sched.sv
// jt51_kon_sched: key-on/key-off scheduler for the envelope generator.
// Stores the CPU key state for 32 operator slots. It walks the slots in step
// with the operator pipeline and emits one keyon/keyoff pulse on each edge.
// Optional CSM (timer A forced key-on) support: define JT51_CSM_EN.
module jt51_kon_sched #(
   parameter int unsigned SLOTS = 32
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef JT51_CSM_EN
   input  logic                       csm_en,
   input  logic                       tima_ovf,
`endif
   input  logic                       zero,
   input  logic                       kon_wr,
   input  logic [2:0]                 kon_ch,
   input  logic [3:0]                 kon_mask,
   output logic [$clog2(SLOTS)-1:0]   slot,
   output logic                       keyon,
   output logic                       keyoff,
   output logic [SLOTS-1:0]           kon_state
);

   localparam int unsigned SW  = $clog2(SLOTS);
   localparam int unsigned OPS = 4;

   logic [SW-1:0]    cnt;
   logic [SW-1:0]    eval_slot_c;
   logic [SLOTS-1:0] prev;
   logic [SLOTS-1:0] kon_next_c;
   logic             csm_now_c;
   logic             want_c;

   // Slot under evaluation: a zero cycle always evaluates slot 0
   always_comb begin
      eval_slot_c = cnt;
      if (zero) eval_slot_c = '0;
   end

   // Key register update: all four operator bits of the channel are rewritten
   always_comb begin
      kon_next_c = kon_state;
      if (kon_wr) begin
         for (int unsigned op = 0; op < OPS; op++)
            kon_next_c[{2'(op), kon_ch}] = kon_mask[2'(op)];
      end
   end

`ifdef JT51_CSM_EN
   logic csm_pend;
   logic csm_active;

   // Forced key-on for the whole round; a zero cycle already sees the new round's value
   always_comb begin
      csm_now_c = csm_active;
      if (zero) csm_now_c = csm_pend;
   end

   // CSM request/active flags: a request becomes active at the next round start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csm_pend   <= 1'b0;
         csm_active <= 1'b0;
      end else begin
         if (zero) begin
            csm_active <= csm_pend;
            csm_pend   <= tima_ovf & csm_en;
         end else if (tima_ovf && csm_en) begin
            csm_pend   <= 1'b1;
         end
      end
   end
`else
   // No CSM support: nothing forces key-on
   always_comb csm_now_c = 1'b0;
`endif

   // Requested state for the evaluated slot (uses pre-write key state)
   always_comb want_c = kon_state[eval_slot_c] | csm_now_c;

   // Slot counter, key register, edge detection and registered pulse outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         kon_state <= '0;
         prev      <= '0;
         slot      <= '0;
         keyon     <= 1'b0;
         keyoff    <= 1'b0;
      end else begin
         cnt              <= eval_slot_c + SW'(1);
         kon_state        <= kon_next_c;
         prev[eval_slot_c] <= want_c;
         slot             <= eval_slot_c;
         keyon            <=  want_c & ~prev[eval_slot_c];
         keyoff           <= ~want_c &  prev[eval_slot_c];
      end
   end

endmodule

// File: tb/tb_jt51_kon_sched.sv
// Directed self-checking bench for jt51_kon_sched.
// Define JT51_CSM_EN for both RTL and bench to exercise the CSM path.
`timescale 1ns/1ps
module tb_jt51_kon_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        zero;
   logic        kon_wr;
   logic [2:0]  kon_ch;
   logic [3:0]  kon_mask;
   logic [4:0]  slot;
   logic        keyon;
   logic        keyoff;
   logic [31:0] kon_state;
   logic        csm_en;
   logic        tima_ovf;

   int checks   = 0;
   int failures = 0;

   jt51_kon_sched dut (
      .clk       (clk),
      .rst       (rst),
`ifdef JT51_CSM_EN
      .csm_en    (csm_en),
      .tima_ovf  (tima_ovf),
`endif
      .zero      (zero),
      .kon_wr    (kon_wr),
      .kon_ch    (kon_ch),
      .kon_mask  (kon_mask),
      .slot      (slot),
      .keyon     (keyon),
      .keyoff    (keyoff),
      .kon_state (kon_state)
   );

   always #5 clk = ~clk;

   // One-cycle key register write, inputs driven 1 ns after the edge
   task automatic write_kon(input logic [2:0] ch, input logic [3:0] mask);
      kon_wr = 1'b1; kon_ch = ch; kon_mask = mask;
      @(posedge clk); #1;
      kon_wr = 1'b0;
   endtask

   // One full round starting with a zero pulse; collects pulses per slot.
   // wr_at >= 0 places a write in the cycle that evaluates that slot.
   task automatic run_round(input int wr_at, input logic [2:0] wr_ch,
                            input logic [3:0] wr_mask,
                            output logic [31:0] on_v, output logic [31:0] off_v,
                            output int slot_err);
      on_v = '0; off_v = '0; slot_err = 0;
      for (int i = 0; i < 32; i++) begin
         zero = (i == 0);
         if (i == wr_at) begin
            kon_wr = 1'b1; kon_ch = wr_ch; kon_mask = wr_mask;
         end
         @(posedge clk); #1;
         zero = 1'b0; kon_wr = 1'b0;
         if (slot !== 5'(i)) slot_err++;
         if (keyon  === 1'b1) on_v[slot]  = 1'b1;
         if (keyoff === 1'b1) off_v[slot] = 1'b1;
         if (keyon !== 1'b0 && keyoff !== 1'b0) slot_err++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; zero = 1'b0; kon_wr = 1'b0; kon_ch = '0; kon_mask = '0;
      csm_en = 1'b0; tima_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (slot !== 5'd0 || keyon !== 1'b0 || keyoff !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: slot=%0d keyon=%b keyoff=%b, need 0/0/0", slot, keyon, keyoff);
      end
      checks++;
      if (kon_state !== 32'h0) begin
         failures++;
         $display("FAIL reset_kon_state: got %h need 00000000", kon_state);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_idle_rounds();
      logic [31:0] on_v, off_v;
      int serr;
      for (int r = 0; r < 4; r++) begin
         run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
         checks++;
         if (serr != 0) begin
            failures++;
            $display("FAIL idle_slot_seq round %0d: %0d slot errors, need 0", r, serr);
         end
         checks++;
         if (on_v !== 32'h0 || off_v !== 32'h0) begin
            failures++;
            $display("FAIL idle_pulses round %0d: on=%h off=%h need 0/0", r, on_v, off_v);
         end
      end
   endtask

   task automatic test_keyon_keyoff();
      logic [31:0] on_v, off_v;
      int serr;
      write_kon(3'd5, 4'b1001);
      checks++;
      if (kon_state !== 32'h2000_0020) begin
         failures++;
         $display("FAIL kon_state_ch5: got %h need 20000020", kon_state);
      end
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h2000_0020 || off_v !== 32'h0 || serr != 0) begin
         failures++;
         $display("FAIL keyon_ch5: on=%h off=%h serr=%0d need 20000020/0/0", on_v, off_v, serr);
      end
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h0 || off_v !== 32'h0) begin
         failures++;
         $display("FAIL keyon_ch5_repeat: on=%h off=%h need 0/0", on_v, off_v);
      end
      write_kon(3'd5, 4'b0001);
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h0 || off_v !== 32'h2000_0000) begin
         failures++;
         $display("FAIL keyoff_slot29: on=%h off=%h need 0/20000000", on_v, off_v);
      end
      checks++;
      if (kon_state !== 32'h0000_0020) begin
         failures++;
         $display("FAIL kon_state_after_off: got %h need 00000020", kon_state);
      end
   endtask

   task automatic test_same_cycle_write();
      logic [31:0] on_v, off_v;
      int serr;
      run_round(2, 3'd2, 4'hF, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h0404_0400 || off_v !== 32'h0) begin
         failures++;
         $display("FAIL same_cycle_round1: on=%h off=%h need 04040400/0", on_v, off_v);
      end
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h0000_0004 || off_v !== 32'h0) begin
         failures++;
         $display("FAIL same_cycle_round2: on=%h off=%h need 00000004/0", on_v, off_v);
      end
      checks++;
      if (kon_state !== 32'h0404_0424) begin
         failures++;
         $display("FAIL kon_state_ch2: got %h need 04040424", kon_state);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] on_v, off_v;
      int serr;
      write_kon(3'd1, 4'h1);
      zero = 1'b1;
      @(posedge clk); #1;
      zero = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (slot !== 5'd1 || keyon !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_keyon: slot=%0d keyon=%b need 1/1", slot, keyon);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (keyon !== 1'b0 || keyoff !== 1'b0 || kon_state !== 32'h0 || slot !== 5'd0) begin
         failures++;
         $display("FAIL async_reset: keyon=%b keyoff=%b kon_state=%h slot=%0d need 0", keyon, keyoff, kon_state, slot);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      write_kon(3'd0, 4'hF);
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h0101_0101 || off_v !== 32'h0 || serr != 0) begin
         failures++;
         $display("FAIL post_reset_keyon: on=%h off=%h serr=%0d need 01010101/0/0", on_v, off_v, serr);
      end
   endtask

`ifdef JT51_CSM_EN
   task automatic test_csm();
      logic [31:0] on_v, off_v;
      int serr;
      write_kon(3'd0, 4'h0);
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (off_v !== 32'h0101_0101 || kon_state !== 32'h0) begin
         failures++;
         $display("FAIL csm_prep: off=%h kon_state=%h need 01010101/0", off_v, kon_state);
      end
      csm_en = 1'b1; tima_ovf = 1'b1;
      @(posedge clk); #1;
      tima_ovf = 1'b0;
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'hFFFF_FFFF || off_v !== 32'h0) begin
         failures++;
         $display("FAIL csm_keyon_round: on=%h off=%h need ffffffff/0", on_v, off_v);
      end
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h0 || off_v !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL csm_keyoff_round: on=%h off=%h need 0/ffffffff", on_v, off_v);
      end
      csm_en = 1'b0; tima_ovf = 1'b1;
      @(posedge clk); #1;
      tima_ovf = 1'b0;
      run_round(-1, 3'd0, 4'h0, on_v, off_v, serr);
      checks++;
      if (on_v !== 32'h0 || off_v !== 32'h0) begin
         failures++;
         $display("FAIL csm_disabled: on=%h off=%h need 0/0", on_v, off_v);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_idle_rounds();
      test_keyon_keyoff();
      test_same_cycle_write();
      test_async_reset();
`ifdef JT51_CSM_EN
      test_csm();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
